// File: rtl/bfly_seq.sv
// bfly_seq: in-place radix-2 FFT butterfly address sequencer.
// Issues one operand pair per cycle per stage, with a PIPE_LAT drain between stages.
`default_nettype none

module bfly_seq #(
   parameter int LOG2N    = 3,
   parameter int PIPE_LAT = 2,
   localparam int SW = $clog2(LOG2N + 1),
   localparam int TW = (LOG2N > 1) ? LOG2N - 1 : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [SW-1:0]    stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr0,
   output logic [LOG2N-1:0] rd_addr1,
   output logic [TW-1:0]    tw_idx,
   output logic             bfly_en,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr0,
   output logic [LOG2N-1:0] wr_addr1
);

   localparam int DW = $clog2(PIPE_LAT + 1);
   localparam logic [LOG2N-1:0] B_LAST = LOG2N'((1 << (LOG2N - 1)) - 1);
   localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
   localparam logic [DW-1:0]    D_LAST = DW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [LOG2N-1:0] b, b_nxt;
   logic [SW-1:0]    s, s_nxt;
   logic [DW-1:0]    dcnt, dcnt_nxt;
   logic [LOG2N-1:0] mask, a0_nxt, a1_nxt;
   logic [TW-1:0]    tw_nxt;

   logic [PIPE_LAT-1:0] en_pipe;
   logic [LOG2N-1:0]    a0_pipe [PIPE_LAT];
   logic [LOG2N-1:0]    a1_pipe [PIPE_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         b     <= '0;
         s     <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         b     <= b_nxt;
         s     <= s_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      b_nxt     = b;
      s_nxt     = s;
      dcnt_nxt  = dcnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               b_nxt     = '0;
               s_nxt     = '0;
            end
         end
         ISSUE: begin
            if (b == B_LAST) begin
               state_nxt = DRAIN;
               dcnt_nxt  = '0;
            end else begin
               b_nxt = b + LOG2N'(1);
            end
         end
         DRAIN: begin
            if (dcnt == D_LAST) begin
               if (s == S_LAST) begin
                  state_nxt = FIN;
               end else begin
                  state_nxt = ISSUE;
                  s_nxt     = s + SW'(1);
                  b_nxt     = '0;
               end
            end else begin
               dcnt_nxt = dcnt + DW'(1);
            end
         end
         FIN: begin
            state_nxt = IDLE;
            s_nxt     = '0;
            b_nxt     = '0;
         end
         default: state_nxt = IDLE;
      endcase
      // abort overrides every transition, including a start in IDLE
      if (abort) begin
         state_nxt = IDLE;
         b_nxt     = '0;
         s_nxt     = '0;
         dcnt_nxt  = '0;
      end
   end

   // Addresses are computed from next-cycle counters so the outputs can be registered.
   always_comb begin
      mask   = ~({LOG2N{1'b1}} << s_nxt);
      a0_nxt = ((b_nxt >> s_nxt) << (s_nxt + SW'(1))) | (b_nxt & mask);
      a1_nxt = a0_nxt | (LOG2N'(1) << s_nxt);
      tw_nxt = TW'((b_nxt & mask) << (S_LAST - s_nxt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_en    <= 1'b0;
         stage    <= '0;
         rd_addr0 <= '0;
         rd_addr1 <= '0;
         tw_idx   <= '0;
      end else begin
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == FIN);
         rd_en    <= (state_nxt == ISSUE);
         stage    <= s_nxt;
         rd_addr0 <= a0_nxt;
         rd_addr1 <= a1_nxt;
         tw_idx   <= tw_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_pipe <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            a0_pipe[i] <= '0;
            a1_pipe[i] <= '0;
         end
      end else if (abort) begin
         en_pipe <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            a0_pipe[i] <= '0;
            a1_pipe[i] <= '0;
         end
      end else begin
         en_pipe[0] <= rd_en;
         a0_pipe[0] <= rd_addr0;
         a1_pipe[0] <= rd_addr1;
         for (int i = 1; i < PIPE_LAT; i++) begin
            en_pipe[i] <= en_pipe[i-1];
            a0_pipe[i] <= a0_pipe[i-1];
            a1_pipe[i] <= a1_pipe[i-1];
         end
      end
   end

   assign bfly_en  = en_pipe[0];
   assign wr_en    = en_pipe[PIPE_LAT-1];
   assign wr_addr0 = a0_pipe[PIPE_LAT-1];
   assign wr_addr1 = a1_pipe[PIPE_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_bfly_seq.sv
// tb_bfly_seq: scoreboard bench for bfly_seq, two configurations (LOG2N/PIPE_LAT = 3/2 and 1/1).
`timescale 1ns/1ps
`default_nettype none

module tb_bfly_seq;

   typedef struct {
      int cyc;
      int a0;
      int a1;
      int tw;
      int st;
   } item_t;

   localparam int LG [2] = '{3, 1};
   localparam int PL [2] = '{2, 1};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start = '0;
   logic [1:0] abort = '0;

   logic       busy_a, done_a, rd_a, bf_a, wr_a;
   logic [1:0] st_a, tw_a;
   logic [2:0] r0_a, r1_a, w0_a, w1_a;

   logic       busy_b, done_b, rd_b, bf_b, wr_b;
   logic [0:0] st_b, tw_b, r0_b, r1_b, w0_b, w1_b;

   int    cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;
   item_t rd_q [2][$];
   item_t wr_q [2][$];
   int    bf_q [2][$];
   int    dn_q [2][$];
   int    run_lo [2] = '{0, 0};
   int    run_hi [2] = '{-1, -1};

   bfly_seq #(.LOG2N(3), .PIPE_LAT(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .busy(busy_a), .done(done_a), .stage(st_a), .rd_en(rd_a),
      .rd_addr0(r0_a), .rd_addr1(r1_a), .tw_idx(tw_a), .bfly_en(bf_a),
      .wr_en(wr_a), .wr_addr0(w0_a), .wr_addr1(w1_a)
   );

   bfly_seq #(.LOG2N(1), .PIPE_LAT(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .busy(busy_b), .done(done_b), .stage(st_b), .rd_en(rd_b),
      .rd_addr0(r0_b), .rd_addr1(r1_b), .tw_idx(tw_b), .bfly_en(bf_b),
      .wr_en(wr_b), .wr_addr0(w0_b), .wr_addr1(w1_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input int d, input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", d, nm, act, exp, cyc);
      end
   endtask

   // Reference: FFT pair schedule from plain index arithmetic and run timing.
   function automatic void push_run(input int d, input int k);
      int h = 1 << (LG[d] - 1);
      for (int s = 0; s < LG[d]; s++) begin
         for (int b = 0; b < h; b++) begin
            int    span = 1 << s;
            int    pos  = b % span;
            item_t it;
            it.cyc = k + 1 + s * (h + PL[d]) + b;
            it.a0  = (b / span) * 2 * span + pos;
            it.a1  = it.a0 + span;
            it.tw  = pos * (1 << (LG[d] - 1 - s));
            it.st  = s;
            rd_q[d].push_back(it);
            bf_q[d].push_back(it.cyc + 1);
            it.cyc = it.cyc + PL[d];
            wr_q[d].push_back(it);
         end
      end
      run_lo[d] = k + 1;
      run_hi[d] = k + LG[d] * (h + PL[d]) + 1;
      dn_q[d].push_back(run_hi[d]);
   endfunction

   function automatic void model(input int d, input bit s, input bit a);
      bit idle = !(cyc >= run_lo[d] && cyc <= run_hi[d]);
      if (a) begin
         if (!idle && cyc < run_hi[d]) begin
            run_hi[d] = cyc;
            while (rd_q[d].size() > 0 && rd_q[d][rd_q[d].size()-1].cyc > cyc) void'(rd_q[d].pop_back());
            while (wr_q[d].size() > 0 && wr_q[d][wr_q[d].size()-1].cyc > cyc) void'(wr_q[d].pop_back());
            while (bf_q[d].size() > 0 && bf_q[d][bf_q[d].size()-1] > cyc) void'(bf_q[d].pop_back());
            while (dn_q[d].size() > 0 && dn_q[d][dn_q[d].size()-1] > cyc) void'(dn_q[d].pop_back());
         end
      end else if (s && idle) begin
         push_run(d, cyc);
      end
   endfunction

   task automatic mon(input int d, input bit busy, input bit done, input bit rd, input bit bf,
                      input bit wr, input int st, input int r0, input int r1, input int tw,
                      input int w0, input int w1);
      item_t e;
      cmp(d, "busy", int'(busy), int'(cyc >= run_lo[d] && cyc <= run_hi[d]));
      if (rd_q[d].size() > 0 && rd_q[d][0].cyc == cyc) begin
         e = rd_q[d].pop_front();
         cmp(d, "rd_en", int'(rd), 1);
         if (rd) begin
            cmp(d, "rd_addr0", r0, e.a0);
            cmp(d, "rd_addr1", r1, e.a1);
            cmp(d, "tw_idx", tw, e.tw);
            cmp(d, "stage", st, e.st);
         end
      end else begin
         cmp(d, "rd_en", int'(rd), 0);
      end
      if (wr_q[d].size() > 0 && wr_q[d][0].cyc == cyc) begin
         e = wr_q[d].pop_front();
         cmp(d, "wr_en", int'(wr), 1);
         if (wr) begin
            cmp(d, "wr_addr0", w0, e.a0);
            cmp(d, "wr_addr1", w1, e.a1);
         end
      end else begin
         cmp(d, "wr_en", int'(wr), 0);
      end
      if (bf_q[d].size() > 0 && bf_q[d][0] == cyc) begin
         void'(bf_q[d].pop_front());
         cmp(d, "bfly_en", int'(bf), 1);
      end else begin
         cmp(d, "bfly_en", int'(bf), 0);
      end
      if (dn_q[d].size() > 0 && dn_q[d][0] == cyc) begin
         void'(dn_q[d].pop_front());
         cmp(d, "done", int'(done), 1);
      end else begin
         cmp(d, "done", int'(done), 0);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         mon(0, busy_a, done_a, rd_a, bf_a, wr_a, int'(st_a), int'(r0_a), int'(r1_a),
             int'(tw_a), int'(w0_a), int'(w1_a));
         mon(1, busy_b, done_b, rd_b, bf_b, wr_b, int'(st_b), int'(r0_b), int'(r1_b),
             int'(tw_b), int'(w0_b), int'(w1_b));
      end
   endtask

   task automatic chk_zero();
      cmp(0, "rst busy", int'(busy_a), 0);  cmp(1, "rst busy", int'(busy_b), 0);
      cmp(0, "rst done", int'(done_a), 0);  cmp(1, "rst done", int'(done_b), 0);
      cmp(0, "rst rd_en", int'(rd_a), 0);   cmp(1, "rst rd_en", int'(rd_b), 0);
      cmp(0, "rst bfly_en", int'(bf_a), 0); cmp(1, "rst bfly_en", int'(bf_b), 0);
      cmp(0, "rst wr_en", int'(wr_a), 0);   cmp(1, "rst wr_en", int'(wr_b), 0);
      cmp(0, "rst stage", int'(st_a), 0);   cmp(1, "rst stage", int'(st_b), 0);
      cmp(0, "rst addrs", int'({r0_a, r1_a, w0_a, w1_a}), 0);
      cmp(1, "rst addrs", int'({r0_b, r1_b, w0_b, w1_b}), 0);
      cmp(0, "rst tw_idx", int'(tw_a), 0);  cmp(1, "rst tw_idx", int'(tw_b), 0);
   endtask

   task automatic step(input bit s0, input bit a0, input bit s1, input bit a1);
      @(negedge clk);
      #1;
      start = {s1, s0};
      abort = {a1, a0};
      model(0, s0, a0);
      model(1, s1, a1);
   endtask

   task automatic idle_steps(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #1;
      start = '0;
      abort = '0;
      rst_n = 1'b0;
      #1;
      chk_zero();
      for (int d = 0; d < 2; d++) begin
         rd_q[d].delete();
         wr_q[d].delete();
         bf_q[d].delete();
         dn_q[d].delete();
         run_lo[d] = 0;
         run_hi[d] = -1;
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      #1;
      chk_zero();
      rst_n = 1'b1;

      // plain run on both configurations
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle_steps(22);

      // start re-pulsed during stage 1 must be ignored
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle_steps(8);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle_steps(16);

      // abort on stage 1, b = 2, then a fresh full run
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle_steps(8);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle_steps(4);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle_steps(22);

      // start and abort together while idle
      step(1'b1, 1'b1, 1'b1, 1'b1);
      idle_steps(3);

      // reset pulse during stage 0 drain, then a fresh run
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle_steps(5);
      reset_pulse();
      idle_steps(2);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle_steps(22);

      // randomized start/abort traffic
      repeat (600) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      end
      idle_steps(40);

      for (int d = 0; d < 2; d++) begin
         cmp(d, "rd left", rd_q[d].size(), 0);
         cmp(d, "wr left", wr_q[d].size(), 0);
         cmp(d, "done left", dn_q[d].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bfly_seq.md
BFLY_SEQ -- requirements
Module: bfly_seq

Interface
REQ-001 Parameter LOG2N, default 3: log2 of FFT size; N = 2^LOG2N, legal range 1..10.
REQ-002 Parameter PIPE_LAT, default 2: cycles from rd_en to write-back, covering 1 memory read plus 1 butterfly register; legal range 1..8.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin an in-place FFT pass sequence; sampled only in IDLE.
REQ-006 abort  input  1  synchronous abandon of the current run; return to IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when the final write-back of the final stage has been issued.
REQ-009 stage  output  clog2(LOG2N+1)  current stage index of issued reads.
REQ-010 rd_en  output  1  read request for a butterfly operand pair.
REQ-011 rd_addr0, rd_addr1  output  LOG2N each  operand addresses.
REQ-012 tw_idx  output  LOG2N-1 (min 1)  twiddle ROM index for the issued pair.
REQ-013 bfly_en  output  1  butterfly enable, equal to rd_en delayed 1 cycle.
REQ-014 wr_en  output  1  write-back strobe, equal to rd_en delayed PIPE_LAT cycles.
REQ-015 wr_addr0, wr_addr1  output  LOG2N each  rd_addr0/1 delayed PIPE_LAT cycles.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, FIN; reset state IDLE.
REQ-017 IDLE -> ISSUE on start; stage = 0, butterfly counter b = 0.
REQ-018 ISSUE: rd_en = 1 every cycle; b increments 0..N/2-1, one pair per cycle, no bubbles.
REQ-019 Addressing for stage s, span = 2^s: pos = b mod span; addr0 = (b >> s)*2*span + pos; addr1 = addr0 + span; tw_idx = pos << (LOG2N-1-s).
REQ-020 ISSUE -> DRAIN the cycle after b = N/2-1 is issued; rd_en = 0 in DRAIN.
REQ-021 DRAIN lasts exactly PIPE_LAT cycles, which is the stage barrier preventing read-after-write hazards; afterwards, if s < LOG2N-1, then s increments, b = 0, and the FSM returns to ISSUE; otherwise it moves to FIN.
REQ-022 FIN lasts one cycle with done = 1, then IDLE; at done the last wr_en has been issued on the same or an earlier cycle.
REQ-023 Counters are unsigned; b wraps to 0 at stage change only, never mid-stage.
REQ-024 start while busy = 1 is ignored, with no restart and no queueing.
REQ-025 abort has priority over every transition: next state IDLE, rd_en = 0 next cycle, the delay pipeline flushed so wr_en = 0 and bfly_en = 0 next cycle, and done not asserted.
REQ-026 start and abort asserted together in IDLE: abort wins and the FSM stays IDLE.
REQ-027 A run takes LOG2N*(N/2 + PIPE_LAT) + 1 cycles from the cycle after start to done inclusive.
REQ-028 All outputs are registered.

Reset
REQ-029 While rst_n = 0: state IDLE; busy, done, rd_en, bfly_en and wr_en are 0; stage, addresses and tw_idx are 0; the delay pipeline is cleared.
REQ-030 Reset asserted mid-run takes effect immediately (asynchronous); after release the block idles until a new start.

Verification
REQ-031 LOG2N=3, PIPE_LAT=2, start pulse -> stage 0 pairs (0,1),(2,3),(4,5),(6,7), tw 0; stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2; stage 2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
REQ-032 Same config -> wr_addr sequence equals rd_addr sequence shifted 2 cycles; 2 idle cycles between stages; done 19 cycles after start.
REQ-033 start pulsed during stage 1 -> ignored; the done count is still 19.
REQ-034 abort during stage 1, issue b = 2 -> next cycle busy = 0, rd_en = 0, wr_en = 0; done never pulses; a fresh start then runs a full correct sequence.
REQ-035 rst_n low for 1 cycle mid-DRAIN -> all outputs 0 asynchronously and the FSM in IDLE.
REQ-036 LOG2N=1, PIPE_LAT=1 -> a single pair (0,1), tw 0, done 3 cycles after start.
